// File: rtl/pb_conditioner_if.sv
// Push-button conditioner bus: raw buttons and acks in; debounced level, strobe and sticky events out.
// Zero latency (wiring only); no backpressure, EVT_ACK is a per-bit pulse.
interface pb_conditioner_if #(
    parameter int N_PBs = 3
);
    logic [N_PBs-1:0] PB_RAW;
    logic [N_PBs-1:0] PB_LEVEL;
    logic [N_PBs-1:0] PB_STROBE;
    logic [N_PBs-1:0] PB_EVT;
    logic [N_PBs-1:0] EVT_ACK;

    modport master (output PB_RAW, output EVT_ACK, input PB_LEVEL, input PB_STROBE, input PB_EVT);
    modport slave  (input PB_RAW, input EVT_ACK, output PB_LEVEL, output PB_STROBE, output PB_EVT);
endinterface

// File: rtl/pb_conditioner.sv
// Per-button sync + debounce + auto-repeat; level/strobe SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles after raw, event flag 1 later.
// No backpressure: strobes merge into sticky PB_EVT until acked, set wins over a same-cycle ack.
module pb_conditioner #(
    parameter int N_PBs           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int CNT_W           = 26
) (
    input logic             CLK,
    input logic             RESETn,
    pb_conditioner_if.slave pb
);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_MAX  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_MAX  = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rstate_e;

    wire [N_PBs-1:0] level_w;
    wire [N_PBs-1:0] strobe_w;
    wire [N_PBs-1:0] evt_w;

    for (genvar i = 0; i < N_PBs; i++) begin : g_pb
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       dcnt_q, dcnt_d;
        logic [CNT_W-1:0]       rcnt_q, rcnt_d;
        logic                   level_q, level_d;
        logic                   strobe_q, strobe_d;
        logic                   evt_q, evt_d;
        rstate_e                state_q, state_d;
        logic                   s, rise, fall;

        always_comb begin
            sync_d   = {sync_q[SYNC_STAGES-2:0], pb.PB_RAW[i]};
            s        = sync_q[SYNC_STAGES-1];
            dcnt_d   = dcnt_q;
            level_d  = level_q;
            rcnt_d   = rcnt_q;
            state_d  = state_q;
            strobe_d = 1'b0;

            // Any sample matching the accepted level restarts the stability count.
            if (s == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DEB_MAX) begin
                level_d = s;
                dcnt_d  = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end

            // Edges are taken from the next level so the press strobe lines up with PB_LEVEL.
            rise = level_d & ~level_q;
            fall = level_q & ~level_d;

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d  = ST_DELAY;
                        strobe_d = 1'b1;
                        rcnt_d   = '0;
                    end
                end
                ST_DELAY: begin
                    if (fall) begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RD_MAX) begin
                        state_d  = ST_REPEAT;
                        strobe_d = 1'b1;
                        rcnt_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (fall) begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RP_MAX) begin
                        strobe_d = 1'b1;
                        rcnt_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end
            endcase

            evt_d = strobe_q | (evt_q & ~pb.EVT_ACK[i]);
        end

        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                sync_q   <= '0;
                dcnt_q   <= '0;
                rcnt_q   <= '0;
                level_q  <= 1'b0;
                strobe_q <= 1'b0;
                evt_q    <= 1'b0;
                state_q  <= ST_IDLE;
            end else begin
                sync_q   <= sync_d;
                dcnt_q   <= dcnt_d;
                rcnt_q   <= rcnt_d;
                level_q  <= level_d;
                strobe_q <= strobe_d;
                evt_q    <= evt_d;
                state_q  <= state_d;
            end
        end

        assign level_w[i]  = level_q;
        assign strobe_w[i] = strobe_q;
        assign evt_w[i]    = evt_q;
    end

    assign pb.PB_LEVEL  = level_w;
    assign pb.PB_STROBE = strobe_w;
    assign pb.PB_EVT    = evt_w;
endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with short debounce/repeat timing.
module tb_pb_conditioner;
    logic CLK;
    logic RESETn;
    int   checks;
    int   failures;

    pb_conditioner_if #(.N_PBs(3)) pb_if ();

    pb_conditioner #(
        .N_PBs(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(10), .CNT_W(26)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .pb(pb_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic ack_all();
        pb_if.EVT_ACK = 3'b111;
        step();
        pb_if.EVT_ACK = 3'b000;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESETn   = 1'b0;
        pb_if.PB_RAW  = 3'b000;
        pb_if.EVT_ACK = 3'b000;
        step();
        step();
        chk("rst_level",  pb_if.PB_LEVEL,  3'b000);
        chk("rst_strobe", pb_if.PB_STROBE, 3'b000);
        chk("rst_evt",    pb_if.PB_EVT,    3'b000);
        RESETn = 1'b1;
        step();
        step();

        // Clean press on bit 1: first sampling edge is c=0.
        pb_if.PB_RAW = 3'b010;
        for (int c = 0; c <= 7; c++) begin
            step();
            chk($sformatf("press_strobe_c%0d", c), pb_if.PB_STROBE, (c == 5) ? 3'b010 : 3'b000);
            chk($sformatf("press_level_c%0d", c),  pb_if.PB_LEVEL,  (c >= 5) ? 3'b010 : 3'b000);
            chk($sformatf("press_evt_c%0d", c),    pb_if.PB_EVT,    (c >= 6) ? 3'b010 : 3'b000);
        end
        pb_if.EVT_ACK = 3'b010;
        step();
        pb_if.EVT_ACK = 3'b000;
        chk("ack_clears", pb_if.PB_EVT, 3'b000);
        pb_if.PB_RAW = 3'b000;
        for (int c = 0; c <= 6; c++) begin
            step();
            chk($sformatf("release_level_c%0d", c),  pb_if.PB_LEVEL,  (c < 5) ? 3'b010 : 3'b000);
            chk($sformatf("release_strobe_c%0d", c), pb_if.PB_STROBE, 3'b000);
        end
        step();

        // Bounce on bit 0, then hold.
        pb_if.PB_RAW = 3'b001; step();
        pb_if.PB_RAW = 3'b000; step();
        pb_if.PB_RAW = 3'b001; step();
        pb_if.PB_RAW = 3'b000; step();
        pb_if.PB_RAW = 3'b001;
        for (int c = 0; c <= 6; c++) begin
            step();
            chk($sformatf("bounce_strobe_c%0d", c), pb_if.PB_STROBE, (c == 5) ? 3'b001 : 3'b000);
        end
        pb_if.PB_RAW = 3'b000;
        for (int c = 0; c < 8; c++) step();
        chk("bounce_released", pb_if.PB_LEVEL, 3'b000);
        ack_all();

        // A 3-cycle pulse is too short to be accepted.
        pb_if.PB_RAW = 3'b001; step(); step(); step();
        pb_if.PB_RAW = 3'b000;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("pulse_strobe_c%0d", c), pb_if.PB_STROBE, 3'b000);
            chk($sformatf("pulse_level_c%0d", c),  pb_if.PB_LEVEL,  3'b000);
        end
        chk("pulse_evt", pb_if.PB_EVT, 3'b000);

        // Auto-repeat on bit 2 held 60 cycles, with two acks.
        pb_if.PB_RAW = 3'b100;
        for (int c = 0; c <= 79; c++) begin
            logic st;
            step();
            pb_if.EVT_ACK = 3'b000;
            st = (c == 5) || (c == 25) || (c == 35) || (c == 45) || (c == 55);
            chk($sformatf("rep_strobe_c%0d", c), pb_if.PB_STROBE, st ? 3'b100 : 3'b000);
            chk($sformatf("rep_level_c%0d", c),  pb_if.PB_LEVEL,
                ((c >= 5) && (c < 65)) ? 3'b100 : 3'b000);
            chk($sformatf("rep_evt_c%0d", c),    pb_if.PB_EVT,
                (((c >= 6) && (c <= 10)) || (c >= 26)) ? 3'b100 : 3'b000);
            if (c == 10 || c == 25) pb_if.EVT_ACK = 3'b100;
            if (c == 59) pb_if.PB_RAW = 3'b000;
        end
        ack_all();
        chk("rep_acked", pb_if.PB_EVT, 3'b000);

        // Simultaneous press; bit 0 released early to show independent repeat.
        pb_if.PB_RAW = 3'b111;
        for (int c = 0; c <= 40; c++) begin
            logic [2:0] lv;
            step();
            lv = 3'b000;
            if (c >= 5) lv[2:1] = 2'b11;
            if (c >= 5 && c < 16) lv[0] = 1'b1;
            chk($sformatf("sim_strobe_c%0d", c), pb_if.PB_STROBE,
                (c == 5) ? 3'b111 : ((c == 25 || c == 35) ? 3'b110 : 3'b000));
            chk($sformatf("sim_level_c%0d", c), pb_if.PB_LEVEL, lv);
            if (c == 6) chk("sim_evt", pb_if.PB_EVT, 3'b111);
            if (c == 10) pb_if.PB_RAW = 3'b110;
        end
        pb_if.PB_RAW = 3'b000;
        for (int c = 0; c < 10; c++) step();
        ack_all();
        chk("sim_idle_level", pb_if.PB_LEVEL, 3'b000);

        // Reset in the middle of DELAY, button still held.
        pb_if.PB_RAW = 3'b001;
        for (int c = 0; c <= 10; c++) step();
        chk("mid_pre_evt",   pb_if.PB_EVT,   3'b001);
        chk("mid_pre_level", pb_if.PB_LEVEL, 3'b001);
        RESETn = 1'b0;
        #1;
        chk("mid_rst_level",  pb_if.PB_LEVEL,  3'b000);
        chk("mid_rst_strobe", pb_if.PB_STROBE, 3'b000);
        chk("mid_rst_evt",    pb_if.PB_EVT,    3'b000);
        step();
        step();
        RESETn = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            step();
            chk($sformatf("post_rst_strobe_c%0d", c), pb_if.PB_STROBE, (c == 5) ? 3'b001 : 3'b000);
        end
        chk("post_rst_evt", pb_if.PB_EVT, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
